// File: rtl/descrambler_lfsr_ctrl.sv
// rtl/descrambler_lfsr_ctrl.sv - per-lane RX LFSR keystream engine and Gen3 descramble-enable decoder

module lfsr_byte_step #(
    parameter int                 width      = 16,
    parameter logic [width-1:0]   poly       = '0,
    parameter int                 data_width = 8
) (
    input  logic [width-1:0]      state,
    output logic [width-1:0]      next_state,
    output logic [data_width-1:0] ks_byte
);

    logic [width-1:0] s_work;

    // Galois LFSR, one keystream bit per step taken from the MSB before the step, LSB first
    always_comb begin
        s_work  = state;
        ks_byte = '0;
        for (int i = 0; i < data_width; i++) begin
            ks_byte[i] = s_work[width-1];
            s_work     = {s_work[width-2:0], 1'b0} ^ (s_work[width-1] ? poly : '0);
        end
        next_state = s_work;
    end

endmodule

module descrambler_lfsr_ctrl #(
    parameter int seed_width         = 24,
    parameter int symbol_count_width = 4,
    parameter int data_width         = 8
) (
    input  logic                          RX_CLK,
    input  logic                          rst,
    input  logic                          GEN,
    input  logic [data_width-1:0]         PIPE_Data,
    input  logic                          PIPE_d_K,
    input  logic                          PIPE_SyncHeader,
    input  logic [symbol_count_width-1:0] count,
    input  logic [seed_width-1:0]         seed,
    input  logic                          LFSR_RST,
    output logic [data_width-1:0]         LFSR_Out_8,
    output logic [data_width-1:0]         LFSR_Out_8_gen3,
    output logic                          descramblingEnable
);

    localparam int                    lfsr16_width = 16;
    localparam int                    lfsr23_width = 23;
    localparam logic [15:0]           poly16       = 16'h0039;
    localparam logic [22:0]           poly23       = 23'h210125;
    localparam logic [15:0]           lfsr16_init  = 16'hFFFF;
    localparam logic [data_width-1:0] sym_com      = data_width'(8'hBC);
    localparam logic [data_width-1:0] sym_skp      = data_width'(8'h1C);
    localparam logic [data_width-1:0] os_ts1       = data_width'(8'h1E);
    localparam logic [data_width-1:0] os_ts2       = data_width'(8'h2D);
    localparam logic [data_width-1:0] os_skp       = data_width'(8'hAA);
    localparam logic [data_width-1:0] os_eieos     = data_width'(8'h00);
    localparam logic [symbol_count_width-1:0] ts_last_sym = symbol_count_width'(13);

    typedef enum logic [1:0] {
        OS_TS    = 2'd0,
        OS_SKP   = 2'd1,
        OS_EIEOS = 2'd2,
        OS_OTHER = 2'd3
    } os_kind_t;

    logic [lfsr16_width-1:0] lfsr16;
    logic [lfsr16_width-1:0] lfsr16_adv;
    logic [lfsr23_width-1:0] lfsr23;
    logic [lfsr23_width-1:0] lfsr23_adv;
    logic [lfsr23_width-1:0] seed_init;
    logic                    blk_os;
    os_kind_t                os_kind;

    logic [data_width-1:0]   ks16;
    logic [data_width-1:0]   ks23;
    os_kind_t                os_kind_dec;
    os_kind_t                os_kind_cur;
    logic                    blk_os_cur;
    logic                    block_start;
    logic                    is_com;
    logic                    is_skp;
    logic                    ts_window;
    logic                    gen3_advance;
    logic                    unused_seed_bits;

    assign seed_init        = seed[lfsr23_width-1:0];
    assign unused_seed_bits = ^seed[seed_width-1:lfsr23_width];

    lfsr_byte_step #(
        .width      (lfsr16_width),
        .poly       (poly16),
        .data_width (data_width)
    ) u_step16 (
        .state      (lfsr16),
        .next_state (lfsr16_adv),
        .ks_byte    (ks16)
    );

    lfsr_byte_step #(
        .width      (lfsr23_width),
        .poly       (poly23),
        .data_width (data_width)
    ) u_step23 (
        .state      (lfsr23),
        .next_state (lfsr23_adv),
        .ks_byte    (ks23)
    );

    always_comb begin
        os_kind_dec = OS_OTHER;
        if (PIPE_Data == os_ts1 || PIPE_Data == os_ts2) begin
            os_kind_dec = OS_TS;
        end else if (PIPE_Data == os_skp) begin
            os_kind_dec = OS_SKP;
        end else if (PIPE_Data == os_eieos) begin
            os_kind_dec = OS_EIEOS;
        end
    end

    // Symbol 0 of a block must already see its own decode, so bypass the registers there
    assign block_start = GEN && (count == '0);
    assign blk_os_cur  = block_start ? PIPE_SyncHeader : blk_os;
    assign os_kind_cur = block_start ? os_kind_dec : os_kind;

    assign is_com       = PIPE_d_K && (PIPE_Data == sym_com);
    assign is_skp       = PIPE_d_K && (PIPE_Data == sym_skp);
    assign ts_window    = (count != '0) && (count <= ts_last_sym);
    assign gen3_advance = !blk_os_cur || (os_kind_cur == OS_TS);

    always_comb begin
        descramblingEnable = 1'b0;
        if (GEN && !rst) begin
            descramblingEnable = blk_os_cur ? ((os_kind_cur == OS_TS) && ts_window) : 1'b1;
        end
    end

    assign LFSR_Out_8      = ks16;
    assign LFSR_Out_8_gen3 = ks23;

    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            blk_os  <= 1'b0;
            os_kind <= OS_OTHER;
        end else if (block_start) begin
            blk_os  <= PIPE_SyncHeader;
            os_kind <= os_kind_dec;
        end
    end

    // LFSR_RST outranks the per-generation rules; the unselected generation always holds
    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            lfsr16 <= lfsr16_init;
        end else if (LFSR_RST) begin
            lfsr16 <= lfsr16_init;
        end else if (!GEN) begin
            if (is_com) begin
                lfsr16 <= lfsr16_init;
            end else if (!is_skp) begin
                lfsr16 <= lfsr16_adv;
            end
        end
    end

    always_ff @(posedge RX_CLK or posedge rst) begin
        if (rst) begin
            lfsr23 <= seed_init;
        end else if (LFSR_RST) begin
            lfsr23 <= seed_init;
        end else if (GEN && gen3_advance) begin
            lfsr23 <= lfsr23_adv;
        end
    end

endmodule
